conv_window_scheduler: RTL and testbench

//  Sequences the 3x3 convolution datapath over a whole image. Holds the 9 kernel weights and walks every valid

---
 rtl/conv_window_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_conv_window_scheduler.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler: walks every 3x3 window of an image, fetches pixel triplets and drives a 3-lane MAC.
// Optional feature macro CONV_SCHED_PERF_EN adds a saturating busy-cycle counter on perf_cycles.

module conv_window_scheduler #(
    parameter int BIT_LENGTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int DIM_WIDTH  = 8
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    cfg_wr,
    input  logic [3:0]              cfg_idx,
    input  logic [BIT_LENGTH-1:0]   cfg_data,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   img_base,
    input  logic [DIM_WIDTH-1:0]    img_width,
    input  logic [DIM_WIDTH-1:0]    img_height,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    mem_rd_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [3*BIT_LENGTH-1:0] mem_rd_data,
    output logic [3*BIT_LENGTH-1:0] mult_a,
    output logic [3*BIT_LENGTH-1:0] mult_b,
    output logic [2:0]              mStart,
    input  logic [2:0]              mReady,
    output logic                    finalAdd,
    input  logic                    finalReady,
    input  logic [2*BIT_LENGTH-1:0] finalAccumulate,
    output logic                    res_valid,
    output logic [2*BIT_LENGTH-1:0] res_data,
    output logic [DIM_WIDTH-1:0]    res_row,
    output logic [DIM_WIDTH-1:0]    res_col,
    input  logic                    res_ready
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [31:0]             perf_cycles
`endif
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_MEMWAIT, S_MUL, S_MULWAIT,
        S_FINAL, S_FINWAIT, S_OUTPUT, S_NEXT, S_DONE
    } state_t;

    state_t                  r_state, w_next;
    logic [BIT_LENGTH-1:0]   r_weight [0:8];
    logic [DIM_WIDTH-1:0]    r_width, r_height, r_row, r_col;
    logic [1:0]              r_krow;
    logic [ADDR_WIDTH-1:0]   r_rowbase, r_colbase, r_line;
    logic [2:0]              r_mrdy;
    logic [3*BIT_LENGTH-1:0] r_mult_a, r_mult_b, w_wrow;
    logic [2*BIT_LENGTH-1:0] r_res_data;
    logic                    r_err, r_err_done;
    logic                    w_bad_dims, w_last_pos;
    logic [DIM_WIDTH-1:0]    w_col_last, w_row_last;
    logic [ADDR_WIDTH-1:0]   w_width_a;

    assign w_bad_dims = (img_width < DIM_WIDTH'(3)) || (img_height < DIM_WIDTH'(3));
    assign w_col_last = r_width - DIM_WIDTH'(3);
    assign w_row_last = r_height - DIM_WIDTH'(3);
    assign w_last_pos = (r_col == w_col_last) && (r_row == w_row_last);
    assign w_width_a  = ADDR_WIDTH'(r_width);

    assign err       = r_err;
    assign mult_a    = r_mult_a;
    assign mult_b    = r_mult_b;
    assign res_data  = r_res_data;
    assign res_row   = r_row;
    assign res_col   = r_col;

    always_comb begin
        w_wrow = '0;
        case (r_krow)
            2'd0:    w_wrow = {r_weight[2], r_weight[1], r_weight[0]};
            2'd1:    w_wrow = {r_weight[5], r_weight[4], r_weight[3]};
            2'd2:    w_wrow = {r_weight[8], r_weight[7], r_weight[6]};
            default: w_wrow = '0;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        busy      = 1'b1;
        done      = r_err_done;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        mStart    = '0;
        finalAdd  = 1'b0;
        res_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start && !w_bad_dims) w_next = S_FETCH;
            end
            S_FETCH: begin
                mem_rd_en = 1'b1;
                mem_addr  = r_line;
                w_next    = S_MEMWAIT;
            end
            S_MEMWAIT: w_next = S_MUL;
            S_MUL: begin
                mStart = 3'b111;
                w_next = S_MULWAIT;
            end
            S_MULWAIT: if (r_mrdy == 3'b111) w_next = (r_krow == 2'd2) ? S_FINAL : S_FETCH;
            S_FINAL: begin
                finalAdd = 1'b1;
                w_next   = S_FINWAIT;
            end
            S_FINWAIT: if (finalReady) w_next = S_OUTPUT;
            S_OUTPUT: begin
                res_valid = 1'b1;
                if (res_ready) w_next = S_NEXT;
            end
            S_NEXT: w_next = w_last_pos ? S_DONE : S_FETCH;
            S_DONE: begin
                busy   = 1'b0;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int unsigned i = 0; i < 9; i++) r_weight[i] <= '0;
        end else if (cfg_wr && !busy && (cfg_idx <= 4'd8)) begin
            r_weight[cfg_idx] <= cfg_data;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_width    <= '0;
            r_height   <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_krow     <= '0;
            r_rowbase  <= '0;
            r_colbase  <= '0;
            r_line     <= '0;
            r_mrdy     <= '0;
            r_mult_a   <= '0;
            r_mult_b   <= '0;
            r_res_data <= '0;
            r_err      <= 1'b0;
            r_err_done <= 1'b0;
        end else begin
            r_err_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    if (w_bad_dims) begin
                        r_err      <= 1'b1;
                        r_err_done <= 1'b1;
                    end else begin
                        r_width   <= img_width;
                        r_height  <= img_height;
                        r_row     <= '0;
                        r_col     <= '0;
                        r_krow    <= '0;
                        r_err     <= 1'b0;
                        r_rowbase <= img_base;
                        r_colbase <= img_base;
                        r_line    <= img_base;
                    end
                end
                // r_line steps one image row per kernel row; NEXT reloads it from the window origin
                S_FETCH: r_line <= r_line + w_width_a;
                S_MEMWAIT: begin
                    r_mult_a <= mem_rd_data;
                    r_mult_b <= w_wrow;
                end
                S_MULWAIT: begin
                    if (r_mrdy == 3'b111) begin
                        r_mrdy <= '0;
                        r_krow <= (r_krow == 2'd2) ? 2'd0 : r_krow + 2'd1;
                    end else begin
                        r_mrdy <= r_mrdy | mReady;
                    end
                end
                S_FINWAIT: if (finalReady) r_res_data <= finalAccumulate;
                S_NEXT: if (!w_last_pos) begin
                    if (r_col == w_col_last) begin
                        r_col     <= '0;
                        r_row     <= r_row + 1'b1;
                        r_rowbase <= r_rowbase + w_width_a;
                        r_colbase <= r_rowbase + w_width_a;
                        r_line    <= r_rowbase + w_width_a;
                    end else begin
                        r_col     <= r_col + 1'b1;
                        r_colbase <= r_colbase + 1'b1;
                        r_line    <= r_colbase + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CONV_SCHED_PERF_EN
    logic [31:0] r_perf;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)                                       r_perf <= '0;
        else if (r_state == S_IDLE && start && !w_bad_dims) r_perf <= '0;
        else if (busy && (r_perf != '1))                  r_perf <= r_perf + 32'd1;
    end

    assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Bench for conv_window_scheduler: image memory and accelerator models, reference convolution over a flat image.
// Builds with or without CONV_SCHED_PERF_EN.

module tb_conv_window_scheduler;

    localparam int BL = 16;
    localparam int AW = 12;
    localparam int DW = 8;

    logic            Clk, Rst_n, cfg_wr, start;
    logic [3:0]      cfg_idx;
    logic [BL-1:0]   cfg_data;
    logic [AW-1:0]   img_base, mem_addr;
    logic [DW-1:0]   img_width, img_height, res_row, res_col;
    logic            busy, done, err, mem_rd_en, finalAdd, finalReady, res_valid, res_ready;
    logic [3*BL-1:0] mem_rd_data, mult_a, mult_b;
    logic [2:0]      mStart, mReady;
    logic [2*BL-1:0] finalAccumulate, res_data;
`ifdef CONV_SCHED_PERF_EN
    logic [31:0]     perf_cycles;
`endif

    conv_window_scheduler #(.BIT_LENGTH(BL), .ADDR_WIDTH(AW), .DIM_WIDTH(DW)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .start(start), .img_base(img_base), .img_width(img_width), .img_height(img_height),
        .busy(busy), .done(done), .err(err), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .mult_a(mult_a), .mult_b(mult_b), .mStart(mStart),
        .mReady(mReady), .finalAdd(finalAdd), .finalReady(finalReady),
        .finalAccumulate(finalAccumulate), .res_valid(res_valid), .res_data(res_data),
        .res_row(res_row), .res_col(res_col), .res_ready(res_ready)
`ifdef CONV_SCHED_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct { int row; int col; logic [31:0] data; } res_t;

    int          errors = 0;
    int          checks = 0;
    res_t        res_q[$];
    res_t        exp_q[$];
    logic [AW-1:0] addr_log[$];
    int          done_cnt = 0, rd_cnt = 0, busy_cnt = 0, mstart_cnt = 0;
    logic        timed_out;
    int          lmul_lo = 2, lmul_hi = 2, lfin = 1;
    logic [15:0] img [0:4095];
    logic [15:0] wts [0:8];

    always @(negedge Clk) begin
        if (res_valid && res_ready) res_q.push_back('{row: int'(res_row), col: int'(res_col), data: res_data});
        if (done) done_cnt++;
        if (mem_rd_en) begin
            rd_cnt++;
            addr_log.push_back(mem_addr);
        end
        if (busy) busy_cnt++;
        if (mStart == 3'b111) mstart_cnt++;
    end

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) mem_rd_data <= '0;
        else if (mem_rd_en)
            mem_rd_data <= {img[AW'(mem_addr + 2)], img[AW'(mem_addr + 1)], img[mem_addr]};
    end

    function automatic logic [31:0] lane_sum(input logic [47:0] a, input logic [47:0] b);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < 3; k++) s = s + 32'(a[k*16 +: 16]) * 32'(b[k*16 +: 16]);
        return s;
    endfunction

    // Accelerator: independent per-lane multiply latency, one dot-product accumulator per window
    int          mcnt [3];
    int          fcnt;
    logic [31:0] acc;
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mReady <= '0; finalReady <= 1'b0; finalAccumulate <= '0; acc <= '0; fcnt <= 0;
            for (int k = 0; k < 3; k++) mcnt[k] <= 0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                mReady[k] <= (mcnt[k] == 1);
                if (mStart == 3'b111) mcnt[k] <= int'($urandom_range(lmul_hi, lmul_lo));
                else if (mcnt[k] != 0) mcnt[k] <= mcnt[k] - 1;
            end
            if (mStart == 3'b111) acc <= acc + lane_sum(mult_a, mult_b);
            finalReady <= (fcnt == 1);
            if (finalAdd) fcnt <= lfin;
            else if (fcnt != 0) fcnt <= fcnt - 1;
            if (fcnt == 1) begin
                finalAccumulate <= acc;
                acc <= '0;
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic write_w(input int idx, input logic [15:0] v);
        tick();
        cfg_wr = 1'b1; cfg_idx = 4'(idx); cfg_data = v;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic load_weights();
        for (int i = 0; i < 9; i++) write_w(i, wts[i]);
    endtask

    task automatic rand_weights();
        for (int i = 0; i < 9; i++) wts[i] = 16'($urandom);
    endtask

    task automatic rand_latency();
        lmul_lo = 1;
        lmul_hi = int'($urandom_range(4, 1));
        lfin    = int'($urandom_range(3, 1));
    endtask

    task automatic start_job(input logic [AW-1:0] b, input int w, input int h);
        tick();
        img_base = b; img_width = DW'(w); img_height = DW'(h); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input bit rnd_ready, input int budget);
        int d0;
        int c;
        d0 = done_cnt;
        c = 0;
        timed_out = 1'b0;
        while (done_cnt == d0 && c < budget) begin
            res_ready = rnd_ready ? 1'($urandom_range(1, 0)) : 1'b1;
            tick();
            c++;
        end
        if (done_cnt == d0) timed_out = 1'b1;
        res_ready = 1'b1;
    endtask

    // Reference: direct 3x3 convolution, addresses wrap modulo the memory size
    task automatic build_expected(input int b, input int w, input int h);
        logic [63:0] s;
        int a;
        exp_q.delete();
        for (int row = 0; row <= h - 3; row++)
            for (int col = 0; col <= w - 3; col++) begin
                s = '0;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++) begin
                        a = (b + (row + r) * w + col + c) % 4096;
                        s = s + 64'(wts[3*r + c]) * 64'(img[a]);
                    end
                exp_q.push_back('{row: row, col: col, data: s[31:0]});
            end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge Clk);
        checks++;
        if ({busy, done, err, mem_rd_en, mStart, finalAdd, res_valid} !== 9'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0", {busy, done, err, mem_rd_en, mStart, finalAdd, res_valid});
        end
        checks++;
        if ({mult_a, mult_b, res_data, res_row, res_col, mem_addr} !== '0) begin
            errors++;
            $display("FAIL reset_data: got a=%0h b=%0h d=%0h r=%0d c=%0d addr=%0h want 0",
                     mult_a, mult_b, res_data, res_row, res_col, mem_addr);
        end
        tick();
        Rst_n = 1'b1;
        repeat (2) @(negedge Clk);
        checks++;
        if ({busy, done, res_valid, mem_rd_en} !== 4'd0) begin
            errors++;
            $display("FAIL reset_idle: got %b want 0", {busy, done, res_valid, mem_rd_en});
        end
    endtask

    task automatic test_ones();
        int erow [4];
        int ecol [4];
        int n0, d0, n;
        erow = '{0, 0, 1, 1};
        ecol = '{0, 1, 0, 1};
        lmul_lo = 2; lmul_hi = 2; lfin = 1;
        for (int i = 0; i < 16; i++) img[i] = 16'd1;
        for (int i = 0; i < 9; i++) wts[i] = 16'd1;
        load_weights();
        n0 = res_q.size(); d0 = done_cnt;
        start_job(12'd0, 4, 4);
        wait_done(1'b0, 2000);
        repeat (3) tick();
        checks++;
        if (timed_out) begin errors++; $display("FAIL ones_timeout: got no done want done"); end
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL ones_done: got %0d pulses want 1", done_cnt - d0); end
        n = res_q.size() - n0;
        checks++;
        if (n != 4) begin errors++; $display("FAIL ones_count: got %0d want 4", n); end
        for (int i = 0; i < n && i < 4; i++) begin
            checks++;
            if (res_q[n0+i].row !== erow[i] || res_q[n0+i].col !== ecol[i] || res_q[n0+i].data !== 32'd9) begin
                errors++;
                $display("FAIL ones_res[%0d]: got (%0d,%0d)=%0d want (%0d,%0d)=9", i,
                         res_q[n0+i].row, res_q[n0+i].col, res_q[n0+i].data, erow[i], ecol[i]);
            end
        end
    endtask

    task automatic test_identity();
        logic [AW-1:0] eaddr [4];
        int n0, a0, n;
        eaddr = '{12'd100, 12'd105, 12'd110, 12'd101};
        for (int a = 100; a < 115; a++) img[a] = 16'(a);
        for (int i = 0; i < 9; i++) wts[i] = (i == 4) ? 16'd1 : 16'd0;
        load_weights();
        n0 = res_q.size(); a0 = addr_log.size();
        start_job(12'd100, 5, 3);
        wait_done(1'b0, 2000);
        checks++;
        if (timed_out) begin errors++; $display("FAIL ident_timeout: got no done want done"); end
        n = res_q.size() - n0;
        checks++;
        if (n != 3) begin errors++; $display("FAIL ident_count: got %0d want 3", n); end
        for (int i = 0; i < n && i < 3; i++) begin
            checks++;
            if (res_q[n0+i].row !== 0 || res_q[n0+i].col !== i || res_q[n0+i].data !== 32'(106 + i)) begin
                errors++;
                $display("FAIL ident_res[%0d]: got (%0d,%0d)=%0d want (0,%0d)=%0d", i,
                         res_q[n0+i].row, res_q[n0+i].col, res_q[n0+i].data, i, 106 + i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (addr_log.size() <= a0 + i || addr_log[a0+i] !== eaddr[i]) begin
                errors++;
                $display("FAIL ident_addr[%0d]: got %0d want %0d", i,
                         (addr_log.size() > a0 + i) ? int'(addr_log[a0+i]) : -1, eaddr[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0]   sd;
        logic [DW-1:0] sr, sc;
        int n0, r0, n, c;
        logic [AW-1:0] b;
        rand_latency(); rand_weights(); load_weights();
        b = AW'($urandom);
        build_expected(int'(b), 5, 4);
        n0 = res_q.size();
        res_ready = 1'b0;
        start_job(b, 5, 4);
        c = 0;
        while (!res_valid && c < 500) begin
            @(negedge Clk);
            c++;
        end
        checks++;
        if (!res_valid) begin errors++; $display("FAIL stall_valid: got res_valid=0 want 1"); end
        sd = res_data; sr = res_row; sc = res_col; r0 = rd_cnt;
        checks++;
        if (sd !== exp_q[0].data || sr !== 8'd0 || sc !== 8'd0) begin
            errors++;
            $display("FAIL stall_first: got (%0d,%0d)=%0h want (0,0)=%0h", sr, sc, sd, exp_q[0].data);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            checks++;
            if (res_valid !== 1'b1 || res_data !== sd || res_row !== sr || res_col !== sc) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b (%0d,%0d)=%0h want v=1 (%0d,%0d)=%0h",
                         i, res_valid, res_row, res_col, res_data, sr, sc, sd);
            end
        end
        checks++;
        if (rd_cnt != r0) begin errors++; $display("FAIL stall_rd: got %0d reads want 0", rd_cnt - r0); end
        tick();
        wait_done(1'b1, 5000);
        checks++;
        if (timed_out) begin errors++; $display("FAIL stall_timeout: got no done want done"); end
        n = res_q.size() - n0;
        checks++;
        if (n != exp_q.size()) begin errors++; $display("FAIL stall_count: got %0d want %0d", n, exp_q.size()); end
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            checks++;
            if (res_q[n0+i].row !== exp_q[i].row || res_q[n0+i].col !== exp_q[i].col || res_q[n0+i].data !== exp_q[i].data) begin
                errors++;
                $display("FAIL stall_res[%0d]: got (%0d,%0d)=%0h want (%0d,%0d)=%0h", i, res_q[n0+i].row,
                         res_q[n0+i].col, res_q[n0+i].data, exp_q[i].row, exp_q[i].col, exp_q[i].data);
            end
        end
    endtask

    task automatic test_bad_dims();
        int r0, d0, n0, n;
        logic [AW-1:0] b;
        r0 = rd_cnt; d0 = done_cnt;
        tick();
        img_base = 12'd0; img_width = 8'd2; img_height = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge Clk);
        checks++;
        if (err !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_first: got err=%b done=%b busy=%b want 1 1 0", err, done, busy);
        end
        @(negedge Clk);
        checks++;
        if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_second: got err=%b done=%b busy=%b want 1 0 0", err, done, busy);
        end
        repeat (3) @(negedge Clk);
        checks++;
        if (rd_cnt != r0 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL bad_quiet: got reads=%0d dones=%0d want 0 1", rd_cnt - r0, done_cnt - d0);
        end
        b = AW'($urandom);
        build_expected(int'(b), 3, 3);
        n0 = res_q.size();
        start_job(b, 3, 3);
        @(negedge Clk);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bad_clear: got err=%b busy=%b want 0 1", err, busy);
        end
        wait_done(1'b0, 2000);
        n = res_q.size() - n0;
        checks++;
        if (timed_out || n != 1 || res_q[n0].data !== exp_q[0].data) begin
            errors++;
            $display("FAIL bad_followup: got n=%0d data=%0h want n=1 data=%0h", n,
                     (n > 0) ? res_q[n0].data : 32'hx, exp_q[0].data);
        end
    endtask

    task automatic test_reset_midjob();
        int m0, c, d0, n0, n;
        logic [AW-1:0] b;
        rand_latency(); rand_weights(); load_weights();
        b = AW'($urandom);
        m0 = mstart_cnt;
        start_job(b, 4, 4);
        c = 0;
        while (mstart_cnt - m0 < 4 && c < 2000) begin
            @(negedge Clk);
            c++;
        end
        checks++;
        if (mstart_cnt - m0 < 4) begin errors++; $display("FAIL midrst_reach: got %0d mStart want 4", mstart_cnt - m0); end
        tick();
        d0 = done_cnt;
        Rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, mem_rd_en, mStart, finalAdd, res_valid} !== 9'd0 ||
            {mult_a, mult_b, res_data, res_row, res_col} !== '0) begin
            errors++;
            $display("FAIL midrst_outs: got ctrl=%b a=%0h b=%0h d=%0h want 0",
                     {busy, done, err, mem_rd_en, mStart, finalAdd, res_valid}, mult_a, mult_b, res_data);
        end
        repeat (3) tick();
        Rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_nodone: got dones=%0d busy=%b want 0 0", done_cnt - d0, busy);
        end
        load_weights();
        build_expected(int'(b), 4, 4);
        n0 = res_q.size();
        start_job(b, 4, 4);
        wait_done(1'b1, 5000);
        n = res_q.size() - n0;
        checks++;
        if (timed_out || n != exp_q.size()) begin
            errors++;
            $display("FAIL midrst_count: got %0d want %0d", n, exp_q.size());
        end
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            checks++;
            if (res_q[n0+i].row !== exp_q[i].row || res_q[n0+i].col !== exp_q[i].col || res_q[n0+i].data !== exp_q[i].data) begin
                errors++;
                $display("FAIL midrst_res[%0d]: got (%0d,%0d)=%0h want (%0d,%0d)=%0h", i, res_q[n0+i].row,
                         res_q[n0+i].col, res_q[n0+i].data, exp_q[i].row, exp_q[i].col, exp_q[i].data);
            end
        end
    endtask

    task automatic test_cfg_guard();
        int n0, n, b0;
        logic [AW-1:0] b;
        rand_latency(); rand_weights(); load_weights();
        write_w(9, ~wts[0]);
        write_w(12, ~wts[1]);
        b = AW'($urandom);
        build_expected(int'(b), 4, 5);
        n0 = res_q.size(); b0 = busy_cnt;
        start_job(b, 4, 5);
        write_w(0, wts[0] ^ 16'h5A5A);
        write_w(8, wts[8] ^ 16'h0FF0);
        wait_done(1'b1, 5000);
        repeat (2) tick();
        n = res_q.size() - n0;
        checks++;
        if (timed_out || n != exp_q.size()) begin
            errors++;
            $display("FAIL cfg_count: got %0d want %0d", n, exp_q.size());
        end
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            checks++;
            if (res_q[n0+i].row !== exp_q[i].row || res_q[n0+i].col !== exp_q[i].col || res_q[n0+i].data !== exp_q[i].data) begin
                errors++;
                $display("FAIL cfg_res[%0d]: got (%0d,%0d)=%0h want (%0d,%0d)=%0h", i, res_q[n0+i].row,
                         res_q[n0+i].col, res_q[n0+i].data, exp_q[i].row, exp_q[i].col, exp_q[i].data);
            end
        end
`ifdef CONV_SCHED_PERF_EN
        checks++;
        if (perf_cycles !== 32'(busy_cnt - b0)) begin
            errors++;
            $display("FAIL perf_cycles: got %0d want %0d", perf_cycles, busy_cnt - b0);
        end
`endif
    endtask

    task automatic test_random();
        int n0, n, d0, w, h;
        logic [AW-1:0] b;
        for (int j = 0; j < 4; j++) begin
            rand_latency(); rand_weights(); load_weights();
            w = int'($urandom_range(7, 3));
            h = int'($urandom_range(6, 3));
            b = AW'($urandom);
            build_expected(int'(b), w, h);
            n0 = res_q.size(); d0 = done_cnt;
            start_job(b, w, h);
            wait_done(1'b1, 8000);
            repeat (2) tick();
            n = res_q.size() - n0;
            checks++;
            if (timed_out || n != exp_q.size() || done_cnt - d0 != 1) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d results %0d dones want %0d 1", j, n, done_cnt - d0, exp_q.size());
            end
            for (int i = 0; i < n && i < exp_q.size(); i++) begin
                checks++;
                if (res_q[n0+i].row !== exp_q[i].row || res_q[n0+i].col !== exp_q[i].col || res_q[n0+i].data !== exp_q[i].data) begin
                    errors++;
                    $display("FAIL rand%0d_res[%0d]: got (%0d,%0d)=%0h want (%0d,%0d)=%0h", j, i, res_q[n0+i].row,
                             res_q[n0+i].col, res_q[n0+i].data, exp_q[i].row, exp_q[i].col, exp_q[i].data);
                end
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n = 1'b0; start = 1'b0; cfg_wr = 1'b0; cfg_idx = '0; cfg_data = '0;
        img_base = '0; img_width = '0; img_height = '0; res_ready = 1'b1;
        for (int i = 0; i < 4096; i++) img[i] = 16'($urandom);
        test_reset();
        test_ones();
        test_identity();
        test_stall();
        test_bad_dims();
        test_reset_midjob();
        test_cfg_guard();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
